wash_cycle_sequencer: RTL
=========================

WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- T_WASH, 4, base wash duration in cycles
- T_RINSE, 3, rinse duration
- T_SPIN, 2, base spin duration
- T_DRAIN, 2, drain duration
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge
- rst, in, 1, synchronous active-high reset
- start, in, 1, request a cycle; sampled only in IDLE
- wash_mode, in, 2, 00 gentle, 01 normal, 10 heavy, 11 treated as normal
- pause, in, 1, level; holds the cycle
- door_open, in, 1, level; holds the cycle and blocks start
- abort, in, 1, pulse; cuts to DRAIN
- wash_motor, out, 1, wash actuator
- rinse_valve, out, 1, rinse actuator
- spin_motor, out, 1, spin actuator
- drain_valve, out, 1, drain actuator
- phase, out, 3, 0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DRAIN
- remaining, out, 8, cycles left in the current phase; 0 in IDLE
- busy, out, 1, high whenever phase is not IDLE
- done, out, 1, one-cycle completion pulse

Function
REQ-003 States SHALL be IDLE, WASH, RINSE, SPIN and DRAIN; phase SHALL equal the registered state.
REQ-004 In IDLE, a start that is high while door_open is low SHALL be accepted, latch wash_mode into an internal register, enter WASH on the next cycle and load remaining.
REQ-005 A start seen outside IDLE, or while door_open is high, SHALL be ignored; it SHALL not be queued.
REQ-006 Let m = latched mode (gentle 1, normal 2, heavy 3). Phase durations SHALL be:
- wash = T_WASH*m
- rinse = T_RINSE
- spin = T_SPIN*m
- drain = T_DRAIN
All products SHALL be computed in 8 bits; parameters SHALL be chosen so that no product exceeds 255.
REQ-007 remaining SHALL load with the phase duration on phase entry.
- It SHALL decrement by 1 on each cycle where hold = pause | door_open is low.
- When remaining==1 and hold is low, the next cycle SHALL enter the next phase with the new duration loaded.
- Each phase therefore lasts exactly its duration in unheld cycles.
REQ-008 The sequence SHALL be WASH -> RINSE -> SPIN -> DRAIN -> IDLE. In heavy mode only, RINSE SHALL run twice: a 1-bit rinse counter re-enters RINSE once before SPIN.
REQ-009 Each actuator output SHALL be high only when phase matches its state and hold is low; at most one actuator SHALL be high at any time.
REQ-010 While hold is high, remaining and state SHALL freeze and all actuators SHALL be low (combinational mask on the current cycle).
REQ-011 abort in WASH, RINSE or SPIN SHALL move the state to DRAIN on the next cycle with remaining = T_DRAIN, regardless of hold.
- abort in DRAIN or IDLE SHALL have no effect.
- abort SHALL take priority over a normal phase-end transition in the same cycle.
REQ-012 done SHALL pulse high for exactly one cycle, coinciding with the first IDLE cycle after DRAIN completes, whether the cycle completed normally or through abort.
REQ-013 A start in the cycle where done is high SHALL be accepted (phase is IDLE).
REQ-014 wash_mode changes after acceptance SHALL not affect the running cycle.

Reset
REQ-015 While rst is high at a clock edge, the block SHALL set:
- state IDLE
- remaining 0
- latched mode gentle
- rinse counter 0
- done 0
- all actuators 0
REQ-016 rst SHALL override start, abort and hold, and SHALL take effect mid-phase with no completion pulse.

Verification
REQ-017 Gentle run with defaults, start at cycle 0: WASH 1-4, RINSE 5-7, SPIN 8-9, DRAIN 10-11, done=1 and phase=0 at cycle 12; exactly one actuator high in cycles 1-11.
REQ-018 Heavy run, start at cycle 0: WASH 1-12, RINSE 13-15, RINSE 16-18, SPIN 19-24, DRAIN 25-26, done at cycle 27.
REQ-019 Gentle run with pause high in cycles 2-4: wash_motor low and remaining frozen at 3 during cycles 2-4; WASH ends at cycle 7; done at cycle 15.
REQ-020 Normal run with abort at cycle 14 (in SPIN): DRAIN in cycles 15-16 with remaining 2 then 1; done at cycle 17. A start at cycle 5 is ignored, and wash_mode=11 gives wash duration 8.
REQ-021 Door and reset:
- start with door_open=1 leaves busy=0.
- rst at cycle 3 of a wash forces phase 0, remaining 0 and all outputs 0 at the next edge, with no done pulse.

Source files
------------

// File: rtl/wash_cycle_sequencer.sv
// wash_cycle_sequencer: sequences a wash / rinse / spin / drain cycle.
// Handles pause/door hold, abort, and a second rinse pass in heavy mode.
module wash_cycle_sequencer #(
    parameter int T_WASH  = 4,
    parameter int T_RINSE = 3,
    parameter int T_SPIN  = 2,
    parameter int T_DRAIN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] wash_mode,
    input  logic       pause,
    input  logic       door_open,
    input  logic       abort,
    output logic       wash_motor,
    output logic       rinse_valve,
    output logic       spin_motor,
    output logic       drain_valve,
    output logic [2:0] phase,
    output logic [7:0] remaining,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE = 3'd0, WASH = 3'd1, RINSE = 3'd2, SPIN = 3'd3, DRAIN = 3'd4} state_t;

    state_t     state, state_n;
    logic [7:0] rem, rem_n;
    logic [1:0] mode, mode_n, mode_sel;
    logic       rinse, rinse_n, done_n, hold;

    function automatic logic [7:0] scale(input logic [7:0] base, input logic [1:0] m);
        return base * {6'd0, m};
    endfunction

    // mode is kept as the multiplier itself: gentle 1, normal 2, heavy 3
    assign mode_sel = wash_mode == 2'b10 ? 2'd3 : wash_mode == 2'b00 ? 2'd1 : 2'd2;
    assign hold     = pause | door_open;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= 8'd0;
            mode  <= 2'd1;
            rinse <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            mode  <= mode_n;
            rinse <= rinse_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        mode_n  = mode;
        rinse_n = rinse;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start && !door_open) begin
                state_n = WASH;
                mode_n  = mode_sel;
                rinse_n = 1'b0;
                rem_n   = scale(8'(T_WASH), mode_sel);
            end
        end else if (abort && state != DRAIN) begin
            state_n = DRAIN;
            rem_n   = 8'(T_DRAIN);
        end else if (!hold) begin
            rem_n = rem - 8'd1;
            if (rem <= 8'd1) begin
                case (state)
                    WASH: begin
                        state_n = RINSE;
                        rem_n   = 8'(T_RINSE);
                    end
                    RINSE: begin
                        state_n = mode == 2'd3 && !rinse ? RINSE : SPIN;
                        rem_n   = mode == 2'd3 && !rinse ? 8'(T_RINSE) : scale(8'(T_SPIN), mode);
                        rinse_n = 1'b1;
                    end
                    SPIN: begin
                        state_n = DRAIN;
                        rem_n   = 8'(T_DRAIN);
                    end
                    default: begin
                        state_n = IDLE;
                        rem_n   = 8'd0;
                        done_n  = 1'b1;
                    end
                endcase
            end
        end
    end

    assign phase       = state;
    assign remaining   = rem;
    assign busy        = state != IDLE;
    assign wash_motor  = state == WASH && !hold;
    assign rinse_valve = state == RINSE && !hold;
    assign spin_motor  = state == SPIN && !hold;
    assign drain_valve = state == DRAIN && !hold;
endmodule
